mfp_gauss_row_filter: RTL and testbench

MFP_GAUSS_ROW_FILTER -- requirements
Module: mfp_gauss_row_filter

---
 rtl/mfp_gauss_row_filter_pkg.sv | 31 +++
 rtl/mfp_gauss_row_filter_mac_tree.sv | 78 +++++++
 rtl/mfp_gauss_row_filter.sv | 142 ++++++++++++++
 tb/tb_mfp_gauss_row_filter.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mfp_gauss_row_filter_pkg.sv
// Shared definitions for the Gaussian row filter: FSM states and width helpers.
package mfp_gauss_row_filter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_RUN,
    ST_FLUSH
  } state_e;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((longint'(1) << i) < longint'(v)) r = i + 1;
    end
    return r;
  endfunction

  // Accumulator width: pixel * coefficient plus growth for TAPS terms and a sign bit.
  function automatic int unsigned acc_width(input int unsigned data_w,
                                            input int unsigned coef_w,
                                            input int unsigned taps);
    return data_w + coef_w + clog2(taps) + 1;
  endfunction

  function automatic longint unsigned round_const(input int unsigned frac);
    return (frac == 0) ? 64'd0 : (64'd1 << (frac - 1));
  endfunction

endpackage

// File: rtl/mfp_gauss_row_filter_mac_tree.sv
// Weighted window sum with round-half-up and clamp to the pixel range; two register stages.
module mfp_mac_tree
  import mfp_gauss_row_filter_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int COEF_W = 8,
  parameter int TAPS   = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [TAPS*DATA_W-1:0]   win,
  input  logic [TAPS*COEF_W-1:0]   coef,
  input  logic                     in_vld,
  input  logic                     in_eol,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_eol
);
  localparam int FRAC  = COEF_W - 1;
  localparam int ACC_W = int'(acc_width(DATA_W, COEF_W, TAPS));
  localparam logic signed [ACC_W-1:0] RND     = ACC_W'(round_const(FRAC));
  localparam logic signed [ACC_W-1:0] PIX_MAX = ACC_W'((longint'(1) << DATA_W) - 1);

  logic signed [ACC_W-1:0] sum_q, sum_d;
  logic                    sum_vld_q, sum_vld_d, sum_eol_q, sum_eol_d;
  logic                    out_valid_q, out_valid_d, out_eol_q, out_eol_d;
  logic [DATA_W-1:0]       out_data_q, out_data_d;
  logic signed [ACC_W-1:0] pix_s, cf_s, rnd, shf;
  logic [DATA_W-1:0]       sat;

  always_comb begin
    pix_s = '0;
    cf_s  = '0;
    sum_d = '0;
    for (int unsigned i = 0; i < TAPS; i++) begin
      pix_s = ACC_W'({1'b0, win[i*DATA_W +: DATA_W]});
      cf_s  = ACC_W'($signed(coef[i*COEF_W +: COEF_W]));
      sum_d = sum_d + pix_s * cf_s;
    end
    if (!en) sum_d = sum_q;

    rnd = sum_q + RND;
    shf = rnd >>> FRAC;
    if (shf[ACC_W-1])      sat = '0;
    else if (shf > PIX_MAX) sat = '1;
    else                    sat = shf[DATA_W-1:0];

    sum_vld_d   = en ? in_vld    : sum_vld_q;
    sum_eol_d   = en ? in_eol    : sum_eol_q;
    out_valid_d = en ? sum_vld_q : out_valid_q;
    out_eol_d   = en ? sum_eol_q : out_eol_q;
    out_data_d  = en ? sat       : out_data_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q       <= '0;
      sum_vld_q   <= 1'b0;
      sum_eol_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_eol_q   <= 1'b0;
      out_data_q  <= '0;
    end else begin
      sum_q       <= sum_d;
      sum_vld_q   <= sum_vld_d;
      sum_eol_q   <= sum_eol_d;
      out_valid_q <= out_valid_d;
      out_eol_q   <= out_eol_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_eol   = out_eol_q;

endmodule

// File: rtl/mfp_gauss_row_filter.sv
// Streaming 1-D Gaussian row filter with edge clamping; FSM and sliding window live here.
module mfp_gauss_row_filter
  import mfp_gauss_row_filter_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int COEF_W   = 8,
  parameter int RAD      = 2,
  parameter int LINE_MAX = 1024
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [COEF_W*(2*RAD+1)-1:0]   coef_arr,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATA_W-1:0]             in_data,
  input  logic                          in_eol,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_W-1:0]             out_data,
  output logic                          out_eol
);
  localparam int TAPS  = 2*RAD + 1;
  localparam int CNT_W = int'(clog2(LINE_MAX + 1));
  localparam int SH_W  = (RAD > 0) ? int'(clog2(RAD + 1)) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LINE_MAX);
  localparam logic [SH_W-1:0]  SH_MAX  = SH_W'(RAD);

  state_e                 state_q, state_d;
  logic [TAPS*DATA_W-1:0] win_q, win_d;
  logic [TAPS*COEF_W-1:0] coef_q, coef_d;
  logic [SH_W-1:0]        shift_cnt_q, shift_cnt_d, shift_inc;
  logic [CNT_W-1:0]       acc_cnt_q, acc_cnt_d, acc_inc;
  logic [CNT_W-1:0]       iss_cnt_q, iss_cnt_d, iss_inc;
  logic                   win_vld_q, win_vld_d, win_eol_q, win_eol_d;
  logic                   en, accept, load, shift, issue;
  logic [DATA_W-1:0]      shift_pix;

  always_comb begin
    en        = !out_valid || out_ready;
    in_ready  = en && (state_q != ST_FLUSH);
    accept    = in_valid && in_ready;
    // Shift count saturates at RAD: only "has it reached RAD" matters downstream.
    shift_inc = (shift_cnt_q == SH_MAX) ? shift_cnt_q : shift_cnt_q + SH_W'(1);
    acc_inc   = (acc_cnt_q == CNT_MAX) ? acc_cnt_q : acc_cnt_q + CNT_W'(1);
    iss_inc   = (iss_cnt_q == CNT_MAX) ? iss_cnt_q : iss_cnt_q + CNT_W'(1);

    state_d     = state_q;
    win_d       = win_q;
    coef_d      = coef_q;
    shift_cnt_d = shift_cnt_q;
    acc_cnt_d   = acc_cnt_q;
    iss_cnt_d   = iss_cnt_q;
    load        = 1'b0;
    shift       = 1'b0;
    shift_pix   = in_data;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          load        = 1'b1;
          win_d       = {TAPS{in_data}};
          coef_d      = coef_arr;
          shift_cnt_d = '0;
          acc_cnt_d   = CNT_W'(1);
          iss_cnt_d   = '0;
          state_d     = in_eol ? ST_FLUSH : ST_FILL;
        end
      end
      ST_FILL, ST_RUN: begin
        if (accept) begin
          shift     = 1'b1;
          acc_cnt_d = acc_inc;
          if (in_eol) state_d = ST_FLUSH;
          else if (state_q == ST_FILL && shift_inc == SH_MAX) state_d = ST_RUN;
        end
      end
      ST_FLUSH: begin
        if (en && iss_cnt_q < acc_cnt_q) begin
          shift     = 1'b1;
          shift_pix = win_q[(TAPS-1)*DATA_W +: DATA_W];
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (shift) begin
      for (int unsigned i = 0; i < TAPS - 1; i++)
        win_d[i*DATA_W +: DATA_W] = win_q[(i+1)*DATA_W +: DATA_W];
      win_d[(TAPS-1)*DATA_W +: DATA_W] = shift_pix;
      shift_cnt_d = shift_inc;
    end

    issue = (load || shift) && (shift_cnt_d == SH_MAX);
    if (issue) iss_cnt_d = load ? CNT_W'(1) : iss_inc;
    if (state_q == ST_FLUSH && en && iss_cnt_d >= acc_cnt_q) state_d = ST_IDLE;

    // The last result is the one that brings issued up to accepted once eol has been seen.
    win_vld_d = en ? issue : win_vld_q;
    win_eol_d = en ? (issue && iss_cnt_d == acc_cnt_d &&
                      (state_d == ST_FLUSH || state_d == ST_IDLE)) : win_eol_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      win_q       <= '0;
      coef_q      <= '0;
      shift_cnt_q <= '0;
      acc_cnt_q   <= '0;
      iss_cnt_q   <= '0;
      win_vld_q   <= 1'b0;
      win_eol_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      win_q       <= win_d;
      coef_q      <= coef_d;
      shift_cnt_q <= shift_cnt_d;
      acc_cnt_q   <= acc_cnt_d;
      iss_cnt_q   <= iss_cnt_d;
      win_vld_q   <= win_vld_d;
      win_eol_q   <= win_eol_d;
    end
  end

  mfp_mac_tree #(
    .DATA_W (DATA_W),
    .COEF_W (COEF_W),
    .TAPS   (TAPS)
  ) u_mac (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .win       (win_q),
    .coef      (coef_q),
    .in_vld    (win_vld_q),
    .in_eol    (win_eol_q),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_eol   (out_eol)
  );

endmodule

// File: tb/tb_mfp_gauss_row_filter.sv
// Randomised bench for mfp_gauss_row_filter against a clamped-convolution reference.
module tb_mfp_gauss_row_filter;
  localparam int DATA_W   = 8;
  localparam int COEF_W   = 8;
  localparam int RAD      = 2;
  localparam int TAPS     = 2*RAD + 1;
  localparam int LINE_MAX = 1024;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [COEF_W*TAPS-1:0]   coef_arr;
  logic                     in_valid, in_ready, in_eol;
  logic [DATA_W-1:0]        in_data;
  logic                     out_valid, out_ready, out_eol;
  logic [DATA_W-1:0]        out_data;

  int n_checks = 0;
  int n_errors = 0;
  int ready_pct = 100;
  int gap_pct   = 0;
  bit mon_en    = 1'b0;
  int cur_coef [TAPS];
  int exp_data [$];
  int exp_eol  [$];

  always #5 clk = ~clk;

  mfp_gauss_row_filter #(
    .DATA_W   (DATA_W),
    .COEF_W   (COEF_W),
    .RAD      (RAD),
    .LINE_MAX (LINE_MAX)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .coef_arr  (coef_arr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_eol    (in_eol),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_eol   (out_eol)
  );

  task automatic chk(input string tag, input int act, input int expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, expv);
    end
  endtask

  // Reference: output k is the kernel applied around pixel k, indices clamped to the line.
  function automatic int ref_pix(input int cf[TAPS], input int px[$], input int k);
    int acc = 0;
    int j;
    for (int i = 0; i < TAPS; i++) begin
      j = k + i - RAD;
      if (j < 0) j = 0;
      if (j > px.size() - 1) j = px.size() - 1;
      acc += cf[i] * px[j];
    end
    acc = (acc + (1 << (COEF_W - 2))) >>> (COEF_W - 1);
    if (acc < 0) acc = 0;
    if (acc > (1 << DATA_W) - 1) acc = (1 << DATA_W) - 1;
    return acc;
  endfunction

  function automatic logic [COEF_W*TAPS-1:0] pack_coef(input int cf[TAPS]);
    logic [COEF_W*TAPS-1:0] v;
    int c;
    v = '0;
    for (int i = 0; i < TAPS; i++) begin
      c = cf[i];
      v[i*COEF_W +: COEF_W] = c[COEF_W-1:0];
    end
    return v;
  endfunction

  initial forever begin
    @(posedge clk);
    #1;
    out_ready = (int'($urandom_range(0, 99)) < ready_pct);
  end

  bit               stalled_prev = 1'b0;
  logic [DATA_W-1:0] held_data;
  logic             held_eol;

  always @(negedge clk) begin
    if (!rst && mon_en) begin
      if (stalled_prev) begin
        chk("hold_valid", int'(out_valid), 1);
        chk("hold_data", int'(out_data), int'(held_data));
        chk("hold_eol", int'(out_eol), int'(held_eol));
      end
      if (out_valid && out_ready) begin
        if (exp_data.size() == 0) begin
          chk("extra_output", int'(out_valid), 0);
        end else begin
          chk("out_data", int'(out_data), exp_data.pop_front());
          chk("out_eol", int'(out_eol), exp_eol.pop_front());
        end
      end
      stalled_prev = out_valid && !out_ready;
      held_data    = out_data;
      held_eol     = out_eol;
    end else begin
      stalled_prev = 1'b0;
    end
  end

  task automatic send_line(input int px[$], input bit eol_last);
    for (int i = 0; i < px.size(); i++) begin
      bit took;
      int t;
      while (int'($urandom_range(0, 99)) < gap_pct) begin
        in_valid = 1'b0;
        @(posedge clk);
        #1;
      end
      in_valid = 1'b1;
      in_data  = DATA_W'(px[i]);
      in_eol   = eol_last && (i == px.size() - 1);
      took = 1'b0;
      t    = 0;
      while (!took && t < 4000) begin
        @(negedge clk);
        took = in_ready;
        @(posedge clk);
        #1;
        t++;
      end
      if (!took) chk("in_accept", int'(took), 1);
      // Coefficients latched at line start; later changes must have no effect.
      if (i == 0) coef_arr = (COEF_W*TAPS)'({$urandom(), $urandom()});
    end
    in_valid = 1'b0;
    in_eol   = 1'b0;
  endtask

  task automatic run_line(input int px[$], input int lit[$]);
    coef_arr = pack_coef(cur_coef);
    for (int k = 0; k < px.size(); k++) begin
      exp_data.push_back((lit.size() != 0) ? lit[k] : ref_pix(cur_coef, px, k));
      exp_eol.push_back((k == px.size() - 1) ? 1 : 0);
    end
    send_line(px, 1'b1);
  endtask

  task automatic drain(input string tag);
    int t = 0;
    while (exp_data.size() != 0 && t < 5000) begin
      @(posedge clk);
      t++;
    end
    chk({tag, "_pending"}, exp_data.size(), 0);
    repeat (12) @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int px [$];
    int lit [$];
    int none [$];
    int n;

    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_eol = 1'b0; out_ready = 1'b0;
    cur_coef = '{8, 32, 48, 32, 8};
    coef_arr = pack_coef(cur_coef);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_out_eol", int'(out_eol), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    mon_en = 1'b1;

    // Flat line of 100s
    px.delete(); lit.delete();
    for (int i = 0; i < 16; i++) begin px.push_back(100); lit.push_back(100); end
    run_line(px, lit);
    drain("const");

    // Impulse, full-rate and then with 30% output readiness
    px  = '{0, 0, 0, 200, 0, 0, 0};
    lit = '{0, 13, 50, 75, 50, 13, 0};
    run_line(px, lit);
    drain("impulse");
    ready_pct = 30;
    run_line(px, lit);
    drain("impulse_bp");
    ready_pct = 100;

    // Short lines and edge clamp
    px = '{10, 20, 30, 40};
    run_line(px, none);
    px = '{77};
    lit = '{77};
    run_line(px, lit);
    px = '{5, 250};
    run_line(px, none);
    drain("short");

    // Saturation at both ends of the pixel range
    cur_coef = '{16, 32, 96, 32, 16};
    px.delete(); lit.delete();
    for (int i = 0; i < 8; i++) begin px.push_back(255); lit.push_back(255); end
    run_line(px, lit);
    cur_coef = '{0, 0, -64, 0, 0};
    lit.delete();
    for (int i = 0; i < 8; i++) lit.push_back(0);
    run_line(px, lit);
    drain("sat");

    // Random lines, random coefficients, input gaps and output stalls
    for (int l = 0; l < 24; l++) begin
      for (int i = 0; i < TAPS; i++) cur_coef[i] = int'($urandom_range(0, 100)) - 30;
      n = int'($urandom_range(1, 20));
      px.delete();
      for (int i = 0; i < n; i++) px.push_back(int'($urandom_range(0, 255)));
      ready_pct = int'($urandom_range(30, 100));
      gap_pct   = int'($urandom_range(0, 40));
      run_line(px, none);
    end
    drain("random");
    ready_pct = 100;
    gap_pct   = 0;

    // Reset in the middle of a line discards it entirely
    mon_en = 1'b0;
    cur_coef = '{8, 32, 48, 32, 8};
    coef_arr = pack_coef(cur_coef);
    px.delete();
    for (int i = 0; i < 5; i++) px.push_back(int'($urandom_range(150, 250)));
    send_line(px, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_in_ready", int'(in_ready), 1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_data.delete();
    exp_eol.delete();
    mon_en = 1'b1;
    px  = '{50, 50, 50};
    lit = '{50, 50, 50};
    run_line(px, lit);
    drain("after_rst");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
